// File: rtl/ascii_uart_tx_if.sv
// Character handshake between an ASCII producer (master) and the serial transmitter (slave).
interface ascii_uart_tx_if #(
  parameter int DATA_W = 7
);
  logic [DATA_W-1:0] ascii;
  logic              valid;
  logic              ready;

  modport master (output ascii, output valid, input ready);
  modport slave  (input ascii, input valid, output ready);
endinterface

// File: rtl/ascii_uart_tx.sv
// Serialises DATA_W-bit characters into start/data(LSB first)/stop frames on tx.
// Define ASCII_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 7
) (
  input  logic           clk,
  input  logic           rst,
  ascii_uart_tx_if.slave in_if,
  output logic           tx,
  output logic           busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef ASCII_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              tx_q;
  logic              bit_done;
`ifdef ASCII_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  always_comb begin
    bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    cnt_d    = bit_done ? '0 : cnt_q + CNT_W'(1);
    shift_d  = shift_q >> 1;
  end

  // tx is loaded one edge ahead of each bit so it is registered yet aligned to the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef ASCII_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_if.valid) begin
            shift_q  <= in_if.ascii;
`ifdef ASCII_UART_TX_PARITY_EN
            parity_q <= ^in_if.ascii;
`endif
            tx_q     <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            if (idx_q == IDX_W'(DATA_W - 1)) begin
              idx_q   <= '0;
`ifdef ASCII_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
            end
          end
        end
`ifdef ASCII_UART_TX_PARITY_EN
        PARITY: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_if.ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx          = tx_q;

endmodule

// File: doc/ascii_uart_tx.md
Name: ascii_uart_tx

Overview:
- Downstream consumer of the one-hot-to-ASCII encoder: takes 7-bit ASCII characters and serialises each as an asynchronous serial frame on a single `tx` line.
- Lets the counter/encoder name sequence leave the chip, or drive a terminal model in the bench.
- Input side uses a valid/ready handshake. Output timing is set by an internal bit-period counter driven from the single system clock.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit. Legal range is >= 1. 4 keeps simulation short.
- DATA_W, 7, character width in bits. Matches the encoder's ASCII output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- ascii  input  DATA_W  character to send. Sampled only on the accept edge.
- valid  input  1  `ascii` holds a character to send.
- ready  output  1  block can accept a character this cycle.
- tx  output  1  serial line. Idle level is 1.
- busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset: one clock (`clk`). Reset `rst` is asynchronous and active-high.
- Reset values, applied immediately when `rst` is asserted: state=IDLE, tx=1, busy=0, ready=1, bit-period counter=0, bit index=0, shift register=0.
- States:
  - IDLE: tx=1, ready=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0].
  - PARITY: present only with the optional feature.
  - STOP: tx=1.
- `ready` is combinational and equals (state==IDLE). `busy` equals (state!=IDLE). `tx` is a registered output.
- Accept: a rising edge with valid=1 and ready=1 does three things:
  - latches `ascii` into the shift register;
  - moves the state to START;
  - drives tx=0 from that edge.
- Latency: first start-bit cycle is the cycle after the accept edge.
- Bit timing:
  - Each of START, each DATA bit, PARITY and STOP holds tx for exactly CLKS_PER_BIT cycles.
  - The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Data order: LSB first. The shift register shifts right at each DATA bit boundary. The bit index counts 0..DATA_W-1.
- Transitions:
  - START to DATA after one bit period.
  - DATA to STOP, or to PARITY when enabled, after DATA_W bit periods.
  - PARITY to STOP after one bit period.
  - STOP to IDLE after one bit period.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, which is 9*CLKS_PER_BIT at defaults.
- Back-to-back frames:
  - IDLE lasts at least one cycle, so the minimum gap is the stop bit plus 1 idle cycle with tx=1.
  - If `valid` is held high, the next character is accepted on the first IDLE edge.
- While busy: `valid` and `ascii` are ignored. Input changes never alter the frame in flight. No character is queued.
- Reset mid-frame: the frame is abandoned and tx returns to 1 asynchronously. After reset release, the block accepts on the first edge with valid=1.
- CLKS_PER_BIT=1: every bit lasts one cycle. No other behaviour changes.

Optional Feature:
- Macro: ASCII_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries even parity, i.e. the XOR of the DATA_W latched bits, for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT cycles.
- When not defined: no PARITY state, no parity logic, and the frame length is (DATA_W+2)*CLKS_PER_BIT cycles.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> tx=1, ready=1, busy=0 immediately. Release rst and hold valid=0 for 10 cycles -> outputs unchanged.
- Single 'M' (0x4D), CLKS_PER_BIT=4, no parity:
  - pulse valid for one cycle;
  - tx runs 0,1,0,1,1,0,0,1,1, each bit held 4 cycles, 36 cycles total;
  - busy=1 for those 36 cycles, ready=0 throughout, then back to IDLE.
- Back-to-back 'M','I' with valid held high:
  - 'I' is accepted on the first IDLE edge;
  - exactly 4 stop cycles plus 1 idle cycle at tx=1 separate the frames;
  - the second frame's data bits are 1,0,0,1,0,0,1 (0x49).
- Input ignored while busy: change ascii to 'X' and pulse valid during the DATA state of 'M' -> the 'M' frame is unaltered and no extra frame follows.
- Reset mid-frame: assert rst during bit 3 of 'A' (0x41) -> tx=1 immediately. Send 'A' after release -> a complete correct frame 0,1,0,0,0,0,0,1,1.
- With ASCII_UART_TX_PARITY_EN defined:
  - 'C' (0x43) -> parity bit 1;
  - 'A' (0x41) -> parity bit 0;
  - each frame is 40 cycles at CLKS_PER_BIT=4.
